// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Holds the FSM state encoding, operand width and debounce default.
package alu_pkg;

    localparam int OP_W = 6;
    localparam int DEB_CYCLES_DEF = 1000000;

    typedef enum logic [2:0] {
        LOAD_X  = 3'd0,
        LOAD_Y  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, optional debounce, rising-edge pulse.
// Debounce filter is built only when ALU_BTN_DEBOUNCE_EN is defined.
module btn_conditioner
    import alu_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic pulse
);

    if (DEB_CYCLES < 1) begin : g_deb_range
        $error("DEB_CYCLES must be at least 1");
    end

    logic s1_q;
    logic s2_q;
    logic lvl;
    logic prev_q;
    logic pulse_q;

`ifdef ALU_BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lvl_q;
    logic          lvl_d;

    // Counter runs only while the synced pin disagrees with the accepted level.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = s2_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= pin;
            s2_q    <= s1_q;
            prev_q  <= lvl;
            pulse_q <= lvl & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps switch values into x, y and op select, then latches the adder result.
// Button debouncing is enabled by defining ALU_BTN_DEBOUNCE_EN.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] sw,
    input  logic            btn_next,
    input  logic            btn_clr,
    output logic [OP_W-1:0] x,
    output logic [OP_W-1:0] y,
    output logic            sel,
    input  logic [OP_W-1:0] sum_in,
    input  logic            cout_in,
    input  logic            ovf_in,
    output logic [OP_W-1:0] result,
    output logic            cout_q,
    output logic            ovf_q,
    output logic            result_valid,
    output logic [2:0]      state
);

    logic next_p;
    logic clr_p;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_next (
        .clk   (clk),
        .reset (reset),
        .pin   (btn_next),
        .pulse (next_p)
    );

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
        .clk   (clk),
        .reset (reset),
        .pin   (btn_clr),
        .pulse (clr_p)
    );

    state_e          state_q, state_d;
    logic [OP_W-1:0] x_q, x_d;
    logic [OP_W-1:0] y_q, y_d;
    logic            sel_q, sel_d;
    logic [OP_W-1:0] result_q, result_d;
    logic            cout_d;
    logic            ovf_d;
    logic            valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        sel_d    = sel_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            LOAD_X: if (next_p) begin
                x_d     = sw;
                state_d = LOAD_Y;
            end
            LOAD_Y: if (next_p) begin
                y_d     = sw;
                state_d = LOAD_OP;
            end
            LOAD_OP: if (next_p) begin
                sel_d   = sw[0];
                state_d = EXEC;
            end
            EXEC: begin
                result_d = sum_in;
                cout_d   = cout_in;
                ovf_d    = ovf_in;
                state_d  = SHOW;
            end
            SHOW: if (next_p) begin
                state_d = LOAD_X;
            end
            default: state_d = LOAD_X;
        endcase
        // Clear overrides any concurrent advance.
        if (clr_p) begin
            state_d  = LOAD_X;
            x_d      = '0;
            y_d      = '0;
            sel_d    = 1'b0;
            result_d = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
        end
        valid_d = (state_d == SHOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD_X;
            x_q      <= '0;
            y_q      <= '0;
            sel_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign sel          = sel_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign state        = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with a bit-level adder/subtractor model.
// Random operand loads are checked against integer arithmetic.
module tb_alu_operand_sequencer;

    localparam int DEB = 4;
`ifdef ALU_BTN_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] sw;
    logic       btn_next;
    logic       btn_clr;
    logic [5:0] x;
    logic [5:0] y;
    logic       sel;
    logic [5:0] sum_in;
    logic       cout_in;
    logic       ovf_in;
    logic [5:0] result;
    logic       cout_q;
    logic       ovf_q;
    logic       result_valid;
    logic [2:0] state;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    // Stand-in for the 6-bit adder/subtractor fed by x, y, sel.
    logic [5:0] b_in;
    assign b_in = y ^ {6{sel}};
    assign {cout_in, sum_in} = {1'b0, x} + {1'b0, b_in} + {6'd0, sel};
    assign ovf_in = (x[5] == b_in[5]) && (sum_in[5] != x[5]);

    alu_operand_sequencer #(.DEB_CYCLES(DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .btn_next     (btn_next),
        .btn_clr      (btn_clr),
        .x            (x),
        .y            (y),
        .sel          (sel),
        .sum_in       (sum_in),
        .cout_in      (cout_in),
        .ovf_in       (ovf_in),
        .result       (result),
        .cout_q       (cout_q),
        .ovf_q        (ovf_q),
        .result_valid (result_valid),
        .state        (state)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic nx, input logic cl);
        tick();
        btn_next = nx;
        btn_clr  = cl;
        repeat (LAT + 2) tick();
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        repeat (LAT + 2) tick();
        @(negedge clk);
    endtask

    task automatic model(input int a, input int b, input bit s,
                         output int r, output bit c, output bit v);
        int sa, sb, sv, raw;
        sa = (a >= 32) ? a - 64 : a;
        sb = (b >= 32) ? b - 64 : b;
        if (s) begin
            raw = a - b;
            c   = (a >= b);
            sv  = sa - sb;
        end else begin
            raw = a + b;
            c   = (raw > 63);
            sv  = sa + sb;
        end
        r = raw & 63;
        v = (sv > 31) || (sv < -32);
    endtask

    task automatic run_op(input int a, input int b, input int opsw,
                          input string tag);
        int r;
        bit c, v;
        model(a, b, opsw[0], r, c, v);
        sw = 6'(a);
        press(1'b1, 1'b0);
        chk({tag, "_st_y"}, 8'(state), 8'd1);
        chk({tag, "_x"}, 8'(x), 8'(a));
        sw = 6'(b);
        press(1'b1, 1'b0);
        chk({tag, "_st_op"}, 8'(state), 8'd2);
        chk({tag, "_y"}, 8'(y), 8'(b));
        sw = 6'(opsw);
        press(1'b1, 1'b0);
        chk({tag, "_st_show"}, 8'(state), 8'd4);
        chk({tag, "_sel"}, 8'(sel), 8'(opsw[0]));
        chk({tag, "_res"}, 8'(result), 8'(r));
        chk({tag, "_cout"}, 8'(cout_q), 8'(c));
        chk({tag, "_ovf"}, 8'(ovf_q), 8'(v));
        chk({tag, "_valid"}, 8'(result_valid), 8'd1);
        sw = 6'($urandom);
        press(1'b1, 1'b0);
        chk({tag, "_st_x"}, 8'(state), 8'd0);
        chk({tag, "_hold_res"}, 8'(result), 8'(r));
        chk({tag, "_hold_x"}, 8'(x), 8'(a));
        chk({tag, "_novalid"}, 8'(result_valid), 8'd0);
    endtask

    initial begin
        reset    = 1'b1;
        sw       = '0;
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_x", 8'(x), 8'd0);
        chk("rst_y", 8'(y), 8'd0);
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_res", 8'(result), 8'd0);
        chk("rst_flags", 8'({cout_q, ovf_q}), 8'd0);
        chk("rst_valid", 8'(result_valid), 8'd0);

        run_op(5, 3, 0, "add53");
        run_op(5, 3, 1, "sub53");
        run_op(31, 1, 0, "add_ovf");
        for (int i = 0; i < 8; i++) begin
            run_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 63)), $sformatf("rnd%0d", i));
        end

        // Bouncy press from LOAD_X must advance exactly one state.
        tick();
`ifdef ALU_BTN_DEBOUNCE_EN
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            repeat (2) tick();
        end
`endif
        btn_next = 1'b1;
        repeat (10) tick();
        btn_next = 1'b0;
        repeat (LAT + 2) tick();
        @(negedge clk);
        chk("bounce_state", 8'(state), 8'd1);

        sw = 6'd9;
        press(1'b1, 1'b0);
        chk("pre_clr_state", 8'(state), 8'd2);
        sw = 6'h3f;
        press(1'b1, 1'b1);
        chk("clr_state", 8'(state), 8'd0);
        chk("clr_x", 8'(x), 8'd0);
        chk("clr_y", 8'(y), 8'd0);
        chk("clr_sel", 8'(sel), 8'd0);
        chk("clr_res", 8'(result), 8'd0);
        chk("clr_flags", 8'({cout_q, ovf_q}), 8'd0);

        run_op(7, 2, 0, "pre_rst");
        sw = 6'd12;
        press(1'b1, 1'b0);
        sw = 6'd20;
        press(1'b1, 1'b0);
        sw = 6'd1;
        press(1'b1, 1'b0);
        chk("show_before_rst", 8'(state), 8'd4);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", 8'(state), 8'd0);
        chk("mid_rst_xy", 8'({x, sel}), 8'd0);
        chk("mid_rst_y", 8'(y), 8'd0);
        chk("mid_rst_res", 8'(result), 8'd0);
        chk("mid_rst_flags", 8'({cout_q, ovf_q}), 8'd0);
        chk("mid_rst_valid", 8'(result_valid), 8'd0);

        // Button held through reset release gives a single pulse.
        tick();
        sw = 6'd33;
        btn_next = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (LAT + 8) tick();
        btn_next = 1'b0;
        repeat (LAT + 2) tick();
        @(negedge clk);
        chk("held_rst_state", 8'(state), 8'd1);
        chk("held_rst_x", 8'(x), 8'd33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, debounce stability count in clk cycles (10 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz Basys3 oscillator.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sw  input  6  slide-switch operand/op value, asynchronous.
REQ-005 SHALL have port btn_next  input  1  advance push-button, asynchronous, bouncy.
REQ-006 SHALL have port btn_clr  input  1  clear push-button, asynchronous, bouncy.
REQ-007 SHALL have port x  output  6  registered operand A to the 6-bit adder/subtractor.
REQ-008 SHALL have port y  output  6  registered operand B to the adder/subtractor.
REQ-009 SHALL have port sel  output  1  registered op select, 0 add, 1 subtract.
REQ-010 SHALL have port sum_in  input  6  adder result.
REQ-011 SHALL have port cout_in  input  1  adder carry out.
REQ-012 SHALL have port ovf_in  input  1  adder signed overflow.
REQ-013 SHALL have port result  output  6  latched result.
REQ-014 SHALL have port cout_q  output  1  latched carry.
REQ-015 SHALL have port ovf_q  output  1  latched overflow.
REQ-016 SHALL have port result_valid  output  1  high while in SHOW.
REQ-017 SHALL have port state  output  3  current FSM state code, for LEDs.

Function
REQ-018 SHALL condition each button into a single-cycle press pulse per debounced rising edge; a held button yields exactly one pulse.
REQ-019 SHALL implement states LOAD_X=0, LOAD_Y=1, LOAD_OP=2, EXEC=3, SHOW=4; codes 5-7 SHALL return to LOAD_X next cycle.
REQ-020 LOAD_X: next pulse -> x<=sw, go LOAD_Y.
REQ-021 LOAD_Y: next pulse -> y<=sw, go LOAD_OP.
REQ-022 LOAD_OP: next pulse -> sel<=sw[0], go EXEC.
REQ-023 EXEC: exactly one cycle; result<=sum_in, cout_q<=cout_in, ovf_q<=ovf_in; go SHOW; next pulses in EXEC ignored.
REQ-024 SHOW: result, flags, x, y, sel held; result_valid=1; next pulse -> LOAD_X without clearing x, y, sel or result.
REQ-025 Clear pulse in any state -> LOAD_X, x, y, sel, result, cout_q, ovf_q all 0 next cycle.
REQ-026 Simultaneous clear and next pulses: clear wins, next discarded.
REQ-027 x, y, sel SHALL change only on the load transitions; combinational adder outputs are stable one full cycle before EXEC samples them.
REQ-028 Pulse latency from first clk edge sampling a stable-high pin: DEB_CYCLES+3 cycles with debounce, 3 cycles without.

Reset
REQ-029 reset SHALL set state=LOAD_X and x, y, sel, result, cout_q, ovf_q, result_valid to 0, and clear synchronizers, debounce counters and edge registers to 0.
REQ-030 Reset asserted mid-operation SHALL abort immediately; a button held high across reset release SHALL produce one pulse after the normal latency.

Configuration
REQ-031 Macro ALU_BTN_DEBOUNCE_EN defined: each button uses 2-flop sync, DEB_CYCLES stability counter (restarted on any synced-level change), debounced level register, edge detect.
REQ-032 Macro undefined: 2-flop sync plus edge detect only; DEB_CYCLES unused; no counter logic synthesised.

Structure
REQ-033 Shared package alu_pkg SHALL hold the state encoding, operand width constant (6) and DEB_CYCLES default.
REQ-034 Sub-module btn_conditioner (sync, optional debounce, edge pulse) SHALL be instantiated once per button.

Verification (bench: DEB_CYCLES=4, x/y/sel wired to the team's 6-bit adder/subtractor)
REQ-035 sw=5 next, sw=3 next, sw=0 next -> EXEC then SHOW: result=8, cout_q=0, ovf_q=0, result_valid=1.
REQ-036 sw=5, 3, 1 (subtract) -> result=2, cout_q=1, ovf_q=0.
REQ-037 sw=31, 1, 0 (add) -> result=6'b100000, ovf_q=1, cout_q=0.
REQ-038 btn_next toggled every 2 cycles for 20 cycles then held high 10 cycles -> exactly one pulse, LOAD_X->LOAD_Y only.
REQ-039 In LOAD_OP, clear and next pulses same cycle -> LOAD_X, all operand/result outputs 0, sel unchanged by sw.
REQ-040 reset asserted one cycle while in SHOW -> next cycle state=0, all outputs 0, result_valid=0.
